// File: rtl/req_adder_hub.sv
// req_adder_hub: CHANNELS requesters share one LAT-stage adder through a
// round-robin arbiter. Results ({sum, channel}) drain through a DEPTH-entry
// FIFO with valid/ready handshake. Grants are credit-gated so the FIFO can
// never overflow.
module req_adder_hub #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 4,
    parameter int LAT      = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CHANNELS-1:0]           req,
    input  logic [CHANNELS*WIDTH-1:0]     a,
    input  logic [CHANNELS*WIDTH-1:0]     b,
    output logic [CHANNELS-1:0]           busy,
    output logic                          c_valid,
    input  logic                          c_ready,
    output logic [WIDTH:0]                c,
    output logic [$clog2(CHANNELS)-1:0]   c_chan
);
    localparam int CW   = $clog2(CHANNELS);
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_FLIGHT} ch_state_t;

    ch_state_t        r_state     [CHANNELS];
    ch_state_t        w_state_nxt [CHANNELS];
    logic [WIDTH-1:0] r_opa       [CHANNELS];
    logic [WIDTH-1:0] r_opb       [CHANNELS];
    logic [CW-1:0]    r_rr;

    logic             w_gnt_vld;
    logic [CW-1:0]    w_gnt_idx;
    int               w_idx;
    int               w_inflight;
    logic             w_credit;

    logic             r_vld_p [LAT];
    logic [WIDTH:0]   r_sum_p [LAT];
    logic [CW-1:0]    r_chan_p[LAT];

    logic [WIDTH:0]   r_mem_sum [DEPTH];
    logic [CW-1:0]    r_mem_chan[DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CNTW-1:0]  r_count;
    logic             w_push;
    logic             w_pop;
    logic [CW-1:0]    w_head_chan;

    // Full-carry sum: operands zero-extended so the carry is never lost
    function automatic logic [WIDTH:0] f_sum(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y);
        return {1'b0, x} + {1'b0, y};
    endfunction

    // Credit: queued plus in-flight results must leave room in the FIFO
    always_comb begin
        w_inflight = 0;
        for (int k = 0; k < LAT; k++) begin
            if (r_vld_p[k]) w_inflight = w_inflight + 1;
        end
        w_credit = (int'(r_count) + w_inflight) < DEPTH;
    end

    // Round-robin search for the first PEND channel starting at r_rr
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_idx     = 0;
        for (int k = 0; k < CHANNELS; k++) begin
            w_idx = (int'(r_rr) + k) % CHANNELS;
            if (!w_gnt_vld && w_credit && r_state[CW'(w_idx)] == ST_PEND) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = CW'(w_idx);
            end
        end
    end

    // Per-channel next state: capture, grant, release on pop
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            w_state_nxt[i] = r_state[i];
            case (r_state[i])
                ST_IDLE:   if (req[i]) w_state_nxt[i] = ST_PEND;
                ST_PEND:   if (w_gnt_vld && w_gnt_idx == CW'(i)) w_state_nxt[i] = ST_FLIGHT;
                ST_FLIGHT: if (w_pop && w_head_chan == CW'(i)) w_state_nxt[i] = ST_IDLE;
                default:   w_state_nxt[i] = ST_IDLE;
            endcase
            busy[i] = (r_state[i] != ST_IDLE);
        end
    end

    // Channel state register
    always_ff @(posedge clk) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (rst) r_state[i] <= ST_IDLE;
            else     r_state[i] <= w_state_nxt[i];
        end
    end

    // Operand capture when an idle channel sees a request
    always_ff @(posedge clk) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (r_state[i] == ST_IDLE && req[i]) begin
                r_opa[i] <= a[i*WIDTH +: WIDTH];
                r_opb[i] <= b[i*WIDTH +: WIDTH];
            end
        end
    end

    // Round-robin pointer moves past the last granted channel
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr <= '0;
        end else if (w_gnt_vld) begin
            r_rr <= (w_gnt_idx == CW'(CHANNELS - 1)) ? '0 : w_gnt_idx + 1'b1;
        end
    end

    // Adder pipeline valids: stage 1 loads on grant, then shifts
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < LAT; k++) r_vld_p[k] <= 1'b0;
        end else begin
            r_vld_p[0] <= w_gnt_vld;
            for (int k = 1; k < LAT; k++) r_vld_p[k] <= r_vld_p[k-1];
        end
    end

    // Adder pipeline data: sum computed from the granted channel's operands
    always_ff @(posedge clk) begin
        r_sum_p[0]  <= f_sum(r_opa[w_gnt_idx], r_opb[w_gnt_idx]);
        r_chan_p[0] <= w_gnt_idx;
        for (int k = 1; k < LAT; k++) begin
            r_sum_p[k]  <= r_sum_p[k-1];
            r_chan_p[k] <= r_chan_p[k-1];
        end
    end

    assign w_push = r_vld_p[LAT-1];
    assign w_pop  = c_valid && c_ready;

    // FIFO pointers and occupancy; push and pop together keep the count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
            if (w_pop)  r_rptr <= (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    // FIFO storage write from the last pipeline stage
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_sum[r_wptr]  <= r_sum_p[LAT-1];
            r_mem_chan[r_wptr] <= r_chan_p[LAT-1];
        end
    end

    // Head presentation, forced to zero while empty
    always_comb begin
        c_valid     = (r_count != '0);
        w_head_chan = r_mem_chan[r_rptr];
        c           = c_valid ? r_mem_sum[r_rptr] : '0;
        c_chan      = c_valid ? w_head_chan : '0;
    end

endmodule

// File: tb/tb_req_adder_hub.sv
// Directed bench for req_adder_hub: latency, multi-channel ordering,
// credit backpressure (DEPTH=2 instance), fairness, reset, busy-hold.
module tb_req_adder_hub;
    logic        clk;
    logic        rst;
    logic [3:0]  req, req2;
    logic [15:0] a, b, a2, b2;
    logic [3:0]  busy, busy2;
    logic        c_valid, c_valid2;
    logic        c_ready, c_ready2;
    logic [4:0]  c, c2;
    logic [1:0]  c_chan, c_chan2;

    int checks = 0;
    int errors = 0;
    int q_chan[$];
    int q_sum[$];
    logic seen;

    req_adder_hub #(.WIDTH(4), .CHANNELS(4), .DEPTH(4), .LAT(2)) u_dut (
        .clk(clk), .rst(rst), .req(req), .a(a), .b(b), .busy(busy),
        .c_valid(c_valid), .c_ready(c_ready), .c(c), .c_chan(c_chan)
    );

    req_adder_hub #(.WIDTH(4), .CHANNELS(4), .DEPTH(2), .LAT(2)) u_dut2 (
        .clk(clk), .rst(rst), .req(req2), .a(a2), .b(b2), .busy(busy2),
        .c_valid(c_valid2), .c_ready(c_ready2), .c(c2), .c_chan(c_chan2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; req = '0; a = '0; b = '0; c_ready = 1'b0;
        req2 = '0; a2 = '0; b2 = '0; c_ready2 = 1'b0;
        tick(); tick();
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_cvalid", 32'(c_valid), 32'h0);
        check("rst_c", 32'(c), 32'h0);
        check("rst_chan", 32'(c_chan), 32'h0);
        check("rst_busy2", 32'(busy2), 32'h0);
        rst = 1'b0;

        // Single request ch0: 7 + 9 = 16
        req = 4'b0001; a = 16'h0007; b = 16'h0009; c_ready = 1'b1;
        tick();                                   // E
        check("t1_busy_E", 32'(busy), 32'h1);
        check("t1_cvalid_E", 32'(c_valid), 32'h0);
        req = '0;
        tick(); check("t1_cvalid_E1", 32'(c_valid), 32'h0);
        tick(); check("t1_cvalid_E2", 32'(c_valid), 32'h0);
        tick();                                   // E+3
        check("t1_cvalid_E3", 32'(c_valid), 32'h1);
        check("t1_c", 32'(c), 32'h10);
        check("t1_chan", 32'(c_chan), 32'h0);
        check("t1_busy_E3", 32'(busy), 32'h1);
        tick();                                   // E+4
        check("t1_busy_E4", 32'(busy), 32'h0);
        check("t1_cvalid_E4", 32'(c_valid), 32'h0);

        // All four channels, rr back at 0
        rst = 1'b1; tick(); rst = 1'b0;
        req = 4'b1111; a = 16'h3210; b = 16'hFFFF;
        tick();                                   // E
        check("t2_busy_E", 32'(busy), 32'hF);
        req = '0;
        tick(); tick(); tick();                   // E+3
        check("t2_v0", 32'(c_valid), 32'h1);
        check("t2_c0", 32'(c), 32'd15);
        check("t2_ch0", 32'(c_chan), 32'd0);
        tick();
        check("t2_c1", 32'(c), 32'd16);
        check("t2_ch1", 32'(c_chan), 32'd1);
        check("t2_busy_E4", 32'(busy), 32'hE);
        tick();
        check("t2_c2", 32'(c), 32'd17);
        check("t2_ch2", 32'(c_chan), 32'd2);
        tick();
        check("t2_c3", 32'(c), 32'd18);
        check("t2_ch3", 32'(c_chan), 32'd3);
        tick();
        check("t2_v_end", 32'(c_valid), 32'h0);
        check("t2_busy_end", 32'(busy), 32'h0);

        // Backpressure on the DEPTH=2 instance
        req2 = 4'b1111; a2 = 16'h3210; b2 = 16'hFFFF; c_ready2 = 1'b0;
        tick();
        req2 = '0;
        for (int i = 0; i < 10; i++) tick();      // X
        check("t3_busy_hold", 32'(busy2), 32'hF);
        check("t3_v_hold", 32'(c_valid2), 32'h1);
        check("t3_c_hold", 32'(c2), 32'd15);
        check("t3_ch_hold", 32'(c_chan2), 32'd0);
        c_ready2 = 1'b1;
        tick();                                   // X+1
        check("t3_c1", 32'(c2), 32'd16);
        check("t3_ch1", 32'(c_chan2), 32'd1);
        check("t3_busy1", 32'(busy2), 32'hE);
        tick();                                   // X+2
        check("t3_gap2", 32'(c_valid2), 32'h0);
        check("t3_busy2", 32'(busy2), 32'hC);
        tick();                                   // X+3
        check("t3_gap3", 32'(c_valid2), 32'h0);
        tick();                                   // X+4
        check("t3_c2", 32'(c2), 32'd17);
        check("t3_ch2", 32'(c_chan2), 32'd2);
        tick();                                   // X+5
        check("t3_c3", 32'(c2), 32'd18);
        check("t3_ch3", 32'(c_chan2), 32'd3);
        check("t3_busy5", 32'(busy2), 32'h8);
        tick();
        check("t3_v_end", 32'(c_valid2), 32'h0);
        check("t3_busy_end", 32'(busy2), 32'h0);

        // Fairness: ch0 and ch1 hold req continuously
        req = 4'b0011; a = 16'h0021; b = 16'h0000; c_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (c_valid) begin
                q_chan.push_back(int'(c_chan));
                q_sum.push_back(int'(c));
            end
        end
        req = '0;
        check("t4_pops", 32'(q_chan.size()), 32'd8);
        for (int i = 0; i < q_chan.size(); i++) begin
            check("t4_order", 32'(q_chan[i]), 32'(i % 2));
            check("t4_sum", 32'(q_sum[i]), 32'((i % 2) + 1));
        end
        tick(); tick(); tick();
        check("t4_idle", 32'(busy), 32'h0);

        // Reset with three results in pipeline/FIFO
        req = 4'b0111; a = 16'h0321; b = 16'h0000; c_ready = 1'b0;
        tick();
        req = '0;
        tick(); tick(); tick();
        check("t5_pre_v", 32'(c_valid), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0; c_ready = 1'b1;
        check("t5_busy", 32'(busy), 32'h0);
        check("t5_v", 32'(c_valid), 32'h0);
        check("t5_c", 32'(c), 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            seen = seen | c_valid | (|busy);
        end
        check("t5_no_stale", 32'(seen), 32'h0);

        // Busy-hold: operands change while ch2 is busy
        req = 4'b0100; a = 16'h0300; b = 16'h0400; c_ready = 1'b1;
        tick();                                   // E
        check("t6_busy_E", 32'(busy), 32'h4);
        a = 16'h0500; b = 16'h0600;
        tick(); tick(); tick();                   // E+3
        check("t6_v", 32'(c_valid), 32'h1);
        check("t6_c", 32'(c), 32'd7);
        check("t6_ch", 32'(c_chan), 32'd2);
        tick();                                   // E+4
        check("t6_rel", 32'(busy), 32'h0);
        tick();                                   // E+5
        check("t6_recap", 32'(busy), 32'h4);
        req = '0;
        tick(); tick(); tick();                   // E+8
        check("t6_v2", 32'(c_valid), 32'h1);
        check("t6_c2", 32'(c), 32'd11);
        check("t6_ch2", 32'(c_chan), 32'd2);
        tick();
        check("t6_end", 32'(busy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
